mouth_frame_buffer: RTL and testbench
=====================================

// Module: mouth_frame_buffer
// PURPOSE
//  Ping-pong frame store sitting directly downstream of the mouth constructor.
//  Captures the streamed pixel address/data/valid writes of one mouth frame into a back bank.
//  Serves the panel refresh driver from the front bank.
//  Swaps banks only at a display frame boundary, so the panel never shows a half-drawn mouth.
// PARAMETERS
//  NUM_BLOCK_ROWS  16   rows per frame
//  NUM_PIXELS      128  pixels per row
//  LOG_POWER_MOD   4    bits per colour channel
//  (derived) TOTAL_ADDRESSES = NUM_BLOCK_ROWS*NUM_PIXELS
//  (derived) ADDRESS_SIZE = $clog2(TOTAL_ADDRESSES)
//  (derived) PIXEL_SIZE = 3*LOG_POWER_MOD
// PORTS
//  clk_in             in   1             system clock
//  rst_n_in           in   1             reset; see BEHAVIOUR
//  pixel_address_in   in   ADDRESS_SIZE  write address, row*NUM_PIXELS+col
//  pixel_data_in      in   PIXEL_SIZE    write pixel
//  pixel_valid_in     in   1             write strobe
//  write_ready_out    out  1             back bank accepting writes
//  frame_sync_in      in   1             1-cycle pulse from driver at start of each refresh frame
//  read_req_in        in   1             read strobe from driver
//  read_address_in    in   ADDRESS_SIZE  read address
//  read_data_out      out  PIXEL_SIZE    front-bank pixel
//  read_valid_out     out  1             read_data_out valid
//  swap_out           out  1             1-cycle pulse: banks swapped this cycle
//  display_bank_out   out  1             index of current front bank
//  dropped_count_out  out  8             saturating count of rejected writes
// BEHAVIOUR
//  Clock and reset (already decided): one clock; reset is synchronous and active-low.
//  - Clock port is clk_in; reset port is rst_n_in.
//  Storage
//  - Two banks of TOTAL_ADDRESSES x PIXEL_SIZE, inferred as BRAM. Contents are not reset.
//  - Back bank = ~display_bank. Read and write therefore never target the same bank.
//  State
//  - display_bank, pending (full frame written, awaiting swap), has_frame (at least one swap since reset).
//  - write_ready_out = !pending (combinational).
//  Write
//  - pixel_valid_in && write_ready_out: back[pixel_address_in] <= pixel_data_in.
//  - Accepted write with pixel_address_in == TOTAL_ADDRESSES-1: pending <= 1 at end of cycle.
//    Last-address write marks frame complete regardless of address order.
//  - pixel_valid_in && !write_ready_out: write dropped; dropped_count +1, saturating at 255.
//  Swap
//  - frame_sync_in && pending: display_bank flips, pending <= 0, has_frame <= 1, swap_out=1 next cycle.
//  - frame_sync_in && !pending: no action.
//  - frame_sync_in in the same cycle as the completing write: no swap this cycle.
//    pending sets and the swap occurs at the next frame_sync_in.
//  Read
//  - Latency 1: read_req_in at cycle N -> read_valid_out=1, read_data_out valid at N+1.
//  - Bank selection is the value of display_bank sampled at cycle N. A read coinciding with a swap uses the old bank.
//  - !has_frame: read_data_out = 0, read_valid_out still asserted.
//  - read_data_out holds its last value when read_valid_out=0.
//  Reset (rst_n_in==0 at a clock edge)
//  - display_bank=0, pending=0, has_frame=0, swap_out=0, read_valid_out=0, read_data_out=0, dropped_count_out=0.
//  - A partially written frame is abandoned. Next reset-free write starts a fresh frame in bank 1.
//  Address widths are exact. TOTAL_ADDRESSES must be a power of two, checked by elaboration assertion.
// TESTING
//  1. Reset, read addr 5 -> read_valid_out=1 next cycle, read_data_out=0. display_bank_out=0, write_ready_out=1.
//  2. Write full frame data=addr[11:0] in order, then frame_sync_in.
//     -> swap_out pulse, display_bank_out=1.
//     -> read addr 0x2A5 returns 0x2A5; read addr 2047 returns 0x7FF.
//  3. Full frame written, no frame_sync_in; write 10 more pixels.
//     -> write_ready_out=0, dropped_count_out=10, front contents unchanged.
//  4. Last-address write and frame_sync_in in same cycle -> no swap_out. Next frame_sync_in -> swap_out, bank flips.
//  5. read_req_in on the swap cycle, front old=0x111 / new=0x222 at addr 7 -> returns 0x111. Next read returns 0x222.
//  6. Reset asserted mid-frame (addr 1000) -> all outputs at reset values. Subsequent 300 drops saturate dropped_count_out at 255.

Source files
------------

// File: rtl/mouth_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// mouth_frame_buffer_if
//   Bundles the pixel-write stream, the panel-driver read/sync signals and the
//   status outputs of the mouth frame buffer.
//
//   Handshake semantics (one rule for the whole interface):
//     A write is taken on a rising clock edge when pixel_valid_in and
//     write_ready_out are both high. If pixel_valid_in is high while
//     write_ready_out is low, the write is discarded and counted, never
//     stalled. read_req_in is always accepted, and read_valid_out pulses one
//     cycle later. frame_sync_in is a one-cycle pulse with no back-pressure.
//
//   Modports
//     master : producer/driver side (mouth constructor + panel driver, or bench)
//     slave  : the frame buffer itself
// -----------------------------------------------------------------------------
`default_nettype none

interface mouth_frame_buffer_if #(
    parameter int ADDRESS_SIZE = 11,
    parameter int PIXEL_SIZE   = 12
);
    logic [ADDRESS_SIZE-1:0] pixel_address_in;
    logic [PIXEL_SIZE-1:0]   pixel_data_in;
    logic                    pixel_valid_in;
    logic                    write_ready_out;
    logic                    frame_sync_in;
    logic                    read_req_in;
    logic [ADDRESS_SIZE-1:0] read_address_in;
    logic [PIXEL_SIZE-1:0]   read_data_out;
    logic                    read_valid_out;
    logic                    swap_out;
    logic                    display_bank_out;
    logic [7:0]              dropped_count_out;

    modport master (
        output pixel_address_in, pixel_data_in, pixel_valid_in,
        output frame_sync_in, read_req_in, read_address_in,
        input  write_ready_out, read_data_out, read_valid_out,
        input  swap_out, display_bank_out, dropped_count_out
    );

    modport slave (
        input  pixel_address_in, pixel_data_in, pixel_valid_in,
        input  frame_sync_in, read_req_in, read_address_in,
        output write_ready_out, read_data_out, read_valid_out,
        output swap_out, display_bank_out, dropped_count_out
    );
endinterface

`default_nettype wire

// File: rtl/mouth_frame_buffer.sv
// -----------------------------------------------------------------------------
// mouth_frame_buffer
//   Ping-pong frame store between the mouth constructor and the panel refresh
//   driver. One frame is written into the back bank while the panel reads the
//   front bank; the banks trade places only on a display frame_sync pulse once
//   a complete frame is waiting, so the panel never shows a half-drawn mouth.
//
//   Ports
//     clk_in    : system clock
//     rst_n_in  : synchronous active-low reset
//     bus       : mouth_frame_buffer_if.slave
//                 pixel_address_in/pixel_data_in/pixel_valid_in -> back-bank write
//                 write_ready_out   : back bank accepting writes (!pending)
//                 frame_sync_in     : start of a refresh frame (swap point)
//                 read_req_in/read_address_in -> front-bank read, latency 1
//                 read_data_out/read_valid_out : read result
//                 swap_out          : 1-cycle pulse after a bank swap
//                 display_bank_out  : index of the front bank
//                 dropped_count_out : saturating count of rejected writes
// -----------------------------------------------------------------------------
`default_nettype none

module mouth_frame_buffer #(
    parameter int NUM_BLOCK_ROWS = 16,
    parameter int NUM_PIXELS     = 128,
    parameter int LOG_POWER_MOD  = 4
) (
    input  wire                   clk_in,
    input  wire                   rst_n_in,
    mouth_frame_buffer_if.slave   bus
);
    localparam int TOTAL_ADDRESSES = NUM_BLOCK_ROWS * NUM_PIXELS;
    localparam int ADDRESS_SIZE    = $clog2(TOTAL_ADDRESSES);
    localparam int PIXEL_SIZE      = 3 * LOG_POWER_MOD;
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDRESS = ADDRESS_SIZE'(TOTAL_ADDRESSES - 1);

    // Addresses are used at exact width, so the frame must fill the address
    // space completely.
    if ((TOTAL_ADDRESSES & (TOTAL_ADDRESSES - 1)) != 0) begin : g_pow2_check
        $error("mouth_frame_buffer: TOTAL_ADDRESSES must be a power of two");
    end

    // ------------------------------------------------------------------
    // Storage: two banks, not reset, so they map onto block RAM.
    // ------------------------------------------------------------------
    logic [PIXEL_SIZE-1:0] r_bank0 [TOTAL_ADDRESSES];
    logic [PIXEL_SIZE-1:0] r_bank1 [TOTAL_ADDRESSES];
    logic [PIXEL_SIZE-1:0] r_rd_data0;
    logic [PIXEL_SIZE-1:0] r_rd_data1;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic       r_display_bank;   // front bank; back bank is the other one
    logic       r_pending;        // complete frame waiting in the back bank
    logic       r_has_frame;      // at least one swap since reset
    logic       r_swap;
    logic       r_read_valid;
    logic       r_rd_sel;         // front bank captured with the read request
    logic       r_rd_zero;        // read issued before any frame was shown
    logic [7:0] r_dropped_count;

    logic w_write_ready;
    logic w_write_accept;
    logic w_write_drop;
    logic w_last_addr;
    logic w_wr_bank0;
    logic w_wr_bank1;
    logic w_do_swap;

    assign w_write_ready  = !r_pending;
    // Writes are ignored while reset is held so an abandoned frame cannot
    // leak into the bank after reset.
    assign w_write_accept = bus.pixel_valid_in && w_write_ready && rst_n_in;
    assign w_write_drop   = bus.pixel_valid_in && !w_write_ready;
    assign w_last_addr    = (bus.pixel_address_in == LAST_ADDRESS);
    assign w_wr_bank0     = w_write_accept && r_display_bank;
    assign w_wr_bank1     = w_write_accept && !r_display_bank;
    // A frame completed in this very cycle has r_pending still low, so the
    // swap naturally waits for the next frame_sync_in.
    assign w_do_swap      = bus.frame_sync_in && r_pending;

    // ------------------------------------------------------------------
    // Bank write and read ports
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_wr_bank0) begin
            r_bank0[bus.pixel_address_in] <= bus.pixel_data_in;
        end
        if (w_wr_bank1) begin
            r_bank1[bus.pixel_address_in] <= bus.pixel_data_in;
        end
        // Both banks are read; the output mux picks the one that was front
        // when the request was made, so a read on a swap cycle sees the
        // old frame.
        if (bus.read_req_in) begin
            r_rd_data0 <= r_bank0[bus.read_address_in];
            r_rd_data1 <= r_bank1[bus.read_address_in];
        end
    end

    // ------------------------------------------------------------------
    // Control, swap, drop counting and read qualification
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_display_bank  <= 1'b0;
            r_pending       <= 1'b0;
            r_has_frame     <= 1'b0;
            r_swap          <= 1'b0;
            r_read_valid    <= 1'b0;
            r_rd_sel        <= 1'b0;
            r_rd_zero       <= 1'b1;
            r_dropped_count <= 8'd0;
        end else begin
            r_swap       <= w_do_swap;
            r_read_valid <= bus.read_req_in;

            if (w_write_accept && w_last_addr) begin
                r_pending <= 1'b1;
            end

            if (w_do_swap) begin
                r_display_bank <= !r_display_bank;
                r_pending      <= 1'b0;
                r_has_frame    <= 1'b1;
            end

            if (w_write_drop && (r_dropped_count != 8'hFF)) begin
                r_dropped_count <= r_dropped_count + 8'd1;
            end

            // Select/zero flags only move with a request, so read_data_out
            // holds its last value between reads.
            if (bus.read_req_in) begin
                r_rd_sel  <= r_display_bank;
                r_rd_zero <= !r_has_frame;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.write_ready_out   = w_write_ready;
    assign bus.read_valid_out    = r_read_valid;
    assign bus.read_data_out     = r_rd_zero ? '0 : (r_rd_sel ? r_rd_data1 : r_rd_data0);
    assign bus.swap_out          = r_swap;
    assign bus.display_bank_out  = r_display_bank;
    assign bus.dropped_count_out = r_dropped_count;

endmodule

`default_nettype wire

// File: tb/tb_mouth_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_mouth_frame_buffer
//   Directed bench for mouth_frame_buffer: reset values, full-frame write and
//   swap, drop counting, coincident completion/sync, read on swap cycle,
//   mid-frame reset and drop-counter saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mouth_frame_buffer;
    localparam int AW    = 11;
    localparam int PW    = 12;
    localparam int TOTAL = 2048;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_n_in;
    always #5 clk_in = ~clk_in;

    mouth_frame_buffer_if #(.ADDRESS_SIZE(AW), .PIXEL_SIZE(PW)) bus ();

    mouth_frame_buffer #(
        .NUM_BLOCK_ROWS (16),
        .NUM_PIXELS     (128),
        .LOG_POWER_MOD  (4)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d, input bit sync);
        bus.pixel_address_in = AW'(a);
        bus.pixel_data_in    = PW'(d);
        bus.pixel_valid_in   = 1'b1;
        bus.frame_sync_in    = sync;
        tick();
        bus.pixel_valid_in   = 1'b0;
        bus.frame_sync_in    = 1'b0;
    endtask

    task automatic rd(input int a);
        bus.read_address_in = AW'(a);
        bus.read_req_in     = 1'b1;
        tick();
        bus.read_req_in     = 1'b0;
    endtask

    task automatic sync_pulse();
        bus.frame_sync_in = 1'b1;
        tick();
        bus.frame_sync_in = 1'b0;
    endtask

    function automatic int f3(input int a);
        return (a == 7) ? 32'h111 : (32'h800 | a);
    endfunction

    function automatic int f4(input int a);
        return (a == 7) ? 32'h222 : (32'h400 | a);
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst_n_in             = 1'b0;
        bus.pixel_address_in = '0;
        bus.pixel_data_in    = '0;
        bus.pixel_valid_in   = 1'b0;
        bus.frame_sync_in    = 1'b0;
        bus.read_req_in      = 1'b0;
        bus.read_address_in  = '0;
        tick();
        tick();
        rst_n_in = 1'b1;

        // 1. reset state and read before any frame
        check("rst_bank",    32'(bus.display_bank_out),  0);
        check("rst_ready",   32'(bus.write_ready_out),   1);
        check("rst_rvalid",  32'(bus.read_valid_out),    0);
        check("rst_rdata",   32'(bus.read_data_out),     0);
        check("rst_swap",    32'(bus.swap_out),          0);
        check("rst_dropped", 32'(bus.dropped_count_out), 0);
        rd(5);
        check("t1_rvalid", 32'(bus.read_valid_out), 1);
        check("t1_rdata",  32'(bus.read_data_out),  0);
        tick();
        check("t1_rvalid_off", 32'(bus.read_valid_out), 0);

        // 2. full frame, data = address, then swap
        for (int a = 0; a < TOTAL; a++) wr(a, a, 1'b0);
        check("t2_ready_low", 32'(bus.write_ready_out), 0);
        check("t2_no_swap_yet", 32'(bus.swap_out), 0);
        sync_pulse();
        check("t2_swap",  32'(bus.swap_out),         1);
        check("t2_bank",  32'(bus.display_bank_out), 1);
        check("t2_ready", 32'(bus.write_ready_out),  1);
        tick();
        check("t2_swap_off", 32'(bus.swap_out), 0);
        rd(12'h2A5);
        check("t2_rd_2a5", 32'(bus.read_data_out), 32'h2A5);
        rd(2047);
        check("t2_rd_7ff", 32'(bus.read_data_out), 32'h7FF);
        check("t2_rvalid", 32'(bus.read_valid_out), 1);

        // 3. fill back bank, no sync, then 10 dropped writes
        for (int a = 0; a < TOTAL; a++) wr(a, f3(a), 1'b0);
        for (int i = 0; i < 10; i++) wr(12'h2A0 + i, 12'hFFF, 1'b0);
        check("t3_ready",   32'(bus.write_ready_out),   0);
        check("t3_dropped", 32'(bus.dropped_count_out), 10);
        check("t3_bank",    32'(bus.display_bank_out),  1);
        rd(12'h2A5);
        check("t3_front_kept", 32'(bus.read_data_out), 32'h2A5);
        sync_pulse();
        check("t3_swap", 32'(bus.swap_out),         1);
        check("t3_bank0", 32'(bus.display_bank_out), 0);
        rd(12'h2A5);
        check("t3_no_drop_write", 32'(bus.read_data_out), 32'hAA5);

        // 4. completing write coincides with frame_sync: no swap yet
        for (int a = 0; a < TOTAL - 1; a++) wr(a, f4(a), 1'b0);
        wr(TOTAL - 1, f4(TOTAL - 1), 1'b1);
        check("t4_no_swap", 32'(bus.swap_out),         0);
        check("t4_bank",    32'(bus.display_bank_out), 0);
        check("t4_pending", 32'(bus.write_ready_out),  0);
        tick();
        check("t4_still_no_swap", 32'(bus.swap_out), 0);

        // 5. read on swap cycle sees old front, next read sees new
        bus.read_address_in = AW'(7);
        bus.read_req_in     = 1'b1;
        bus.frame_sync_in   = 1'b1;
        tick();
        bus.read_req_in     = 1'b0;
        bus.frame_sync_in   = 1'b0;
        check("t5_swap",     32'(bus.swap_out),         1);
        check("t5_bank",     32'(bus.display_bank_out), 1);
        check("t5_rvalid",   32'(bus.read_valid_out),   1);
        check("t5_old_data", 32'(bus.read_data_out),    32'h111);
        rd(7);
        check("t5_new_data", 32'(bus.read_data_out), 32'h222);
        rd(100);
        check("t5_rd_100", 32'(bus.read_data_out), 32'h464);
        tick();
        check("t5_hold_valid", 32'(bus.read_valid_out), 0);
        check("t5_hold_data",  32'(bus.read_data_out),  32'h464);

        // 6. reset mid-frame, then saturate the drop counter
        for (int a = 0; a < 1000; a++) wr(a, 12'h0AB, 1'b0);
        bus.pixel_address_in = AW'(1000);
        bus.pixel_data_in    = PW'(12'h0AB);
        bus.pixel_valid_in   = 1'b1;
        rst_n_in             = 1'b0;
        tick();
        bus.pixel_valid_in   = 1'b0;
        rst_n_in             = 1'b1;
        check("t6_bank",    32'(bus.display_bank_out),  0);
        check("t6_ready",   32'(bus.write_ready_out),   1);
        check("t6_rvalid",  32'(bus.read_valid_out),    0);
        check("t6_rdata",   32'(bus.read_data_out),     0);
        check("t6_swap",    32'(bus.swap_out),          0);
        check("t6_dropped", 32'(bus.dropped_count_out), 0);
        rd(5);
        check("t6_rd_no_frame", 32'(bus.read_data_out),  0);
        check("t6_rd_valid",    32'(bus.read_valid_out), 1);
        for (int a = 0; a < TOTAL; a++) wr(a, 32'hC00 | a, 1'b0);
        for (int i = 0; i < 255; i++) wr(i, 0, 1'b0);
        check("t6_dropped_255", 32'(bus.dropped_count_out), 255);
        for (int i = 0; i < 45; i++) wr(i, 0, 1'b0);
        check("t6_dropped_sat", 32'(bus.dropped_count_out), 255);
        sync_pulse();
        check("t6_swap_bank", 32'(bus.display_bank_out), 1);
        rd(12'h010);
        check("t6_rd_010", 32'(bus.read_data_out), 32'hC10);
        rd(1000);
        check("t6_rd_1000", 32'(bus.read_data_out), 32'hFE8);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
